// File: rtl/iic_master.sv
// I2C register-access master: 16-bit register address, 8-bit data, write or
// read-with-repeated-start, open-drain style pull-down outputs, clock stretching.
module iic_master #(
  parameter logic [15:0] QDIV = 16'd63
) (
  input  logic        MCK,
  input  logic        RSTN,
  input  logic        iSTART,
  input  logic        iRW,
  input  logic [6:0]  iSLAVE,
  input  logic [15:0] iREG,
  input  logic [7:0]  iWDAT,
  output logic [7:0]  oRDAT,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oNACK,
  input  logic        iSCL,
  input  logic        iSDA,
  output logic        dSCL,
  output logic        dSDA
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_SEND   = 3'd2;
  localparam logic [2:0] S_SACK   = 3'd3;
  localparam logic [2:0] S_RSTART = 3'd4;
  localparam logic [2:0] S_RECV   = 3'd5;
  localparam logic [2:0] S_MNACK  = 3'd6;
  localparam logic [2:0] S_STOP   = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  frame_q, frame_d;
  logic [7:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic [6:0]  slave_q, slave_d;
  logic [15:0] reg_q, reg_d;
  logic [7:0]  wdat_q, wdat_d;
  logic [7:0]  rdat_q, rdat_d;
  logic        nack_q, nack_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic        tick, stall, adv, reload;

  // Byte transmitted in a given frame; frame 4 is the read-direction address.
  function automatic logic [7:0] sel_byte(input logic [2:0] f, input logic [6:0] sl,
                                          input logic [15:0] rg, input logic [7:0] wd);
    case (f)
      3'd0:    sel_byte = {sl, 1'b0};
      3'd1:    sel_byte = rg[15:8];
      3'd2:    sel_byte = rg[7:0];
      3'd3:    sel_byte = wd;
      default: sel_byte = {sl, 1'b1};
    endcase
  endfunction

  // State and datapath registers; reset releases the bus at once.
  always_ff @(posedge MCK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      quarter_q <= 2'd0;
      cnt_q     <= 16'd0;
      bit_q     <= 3'd0;
      frame_q   <= 3'd0;
      shift_q   <= 8'h00;
      rw_q      <= 1'b0;
      slave_q   <= 7'h00;
      reg_q     <= 16'h0000;
      wdat_q    <= 8'h00;
      rdat_q    <= 8'h00;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      scl_q     <= 1'b0;
      sda_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      quarter_q <= quarter_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      slave_q   <= slave_d;
      reg_q     <= reg_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      nack_q    <= nack_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
    end
  end

  // Next-state, quarter sequencing and registered bus drive.
  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    slave_d   = slave_q;
    reg_d     = reg_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    reload    = 1'b0;
    scl_d     = 1'b0;
    sda_d     = 1'b0;

    tick  = (cnt_q == 16'd0);
    // Only stretch while SCL is released by us but still seen low on the bus.
    stall = quarter_q[1] && !scl_q && !iSCL;
    adv   = (state_q != S_IDLE) && tick && !stall;

    if (state_q == S_IDLE) begin
      if (iSTART) begin
        rw_d      = iRW;
        slave_d   = iSLAVE;
        reg_d     = iREG;
        wdat_d    = iWDAT;
        nack_d    = 1'b0;
        state_d   = S_START;
        quarter_d = 2'd0;
        frame_d   = 3'd0;
        bit_d     = 3'd0;
        reload    = 1'b1;
      end
    end else if (adv) begin
      reload = 1'b1;
      if (state_q == S_RSTART) begin
        // Single quarter releasing SDA under low SCL, then a normal START.
        state_d   = S_START;
        quarter_d = 2'd0;
      end else if (quarter_q != 2'd3) begin
        quarter_d = quarter_q + 2'd1;
        if (quarter_q == 2'd2) begin
          if (state_q == S_SACK && iSDA) nack_d = 1'b1;
          if (state_q == S_RECV) shift_d = {shift_q[6:0], iSDA};
        end
      end else begin
        quarter_d = 2'd0;
        case (state_q)
          S_START: begin
            state_d = S_SEND;
            bit_d   = 3'd0;
            shift_d = sel_byte(frame_q, slave_q, reg_q, wdat_q);
          end
          S_SEND: begin
            if (bit_q == 3'd7) begin
              state_d = S_SACK;
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
          S_SACK: begin
            if (nack_q) begin
              state_d = S_STOP;
            end else if (frame_q == 3'd4) begin
              state_d = S_RECV;
              bit_d   = 3'd0;
            end else if (frame_q == 3'd3) begin
              state_d = S_STOP;
            end else if (frame_q == 3'd2 && rw_q) begin
              state_d = S_RSTART;
              frame_d = 3'd4;
            end else begin
              state_d = S_SEND;
              frame_d = frame_q + 3'd1;
              bit_d   = 3'd0;
              shift_d = sel_byte(frame_q + 3'd1, slave_q, reg_q, wdat_q);
            end
          end
          S_RECV: begin
            if (bit_q == 3'd7) begin
              state_d = S_MNACK;
              rdat_d  = shift_q;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
          S_MNACK: state_d = S_STOP;
          S_STOP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    if (state_d == S_IDLE) cnt_d = 16'd0;
    else if (reload)       cnt_d = 16'(QDIV - 16'd1);
    else if (!stall)       cnt_d = cnt_q - 16'd1;

    busy_d = (state_d != S_IDLE);

    case (state_d)
      S_START: begin
        scl_d = (quarter_d == 2'd3);
        sda_d = (quarter_d != 2'd0);
      end
      S_SEND: begin
        scl_d = !quarter_d[1];
        sda_d = !shift_d[7];
      end
      S_SACK, S_RECV, S_MNACK: scl_d = !quarter_d[1];
      S_RSTART: scl_d = 1'b1;
      S_STOP: begin
        scl_d = (quarter_d == 2'd0);
        sda_d = (quarter_d != 2'd3);
      end
      default: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
      end
    endcase
  end

  assign oRDAT = rdat_q;
  assign oBUSY = busy_q;
  assign oDONE = done_q;
  assign oNACK = nack_q;
  assign dSCL  = scl_q;
  assign dSDA  = sda_q;

endmodule

// File: doc/iic_master.md
IIC_MASTER -- requirements
Module: iic_master

Interface
REQ-001 SHALL have parameter QDIV, default 16'd63; MCK cycles per SCL quarter-period; legal range 2..65535.
REQ-002 SHALL have port MCK  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port RSTN  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iSTART  in  1  single-cycle request; accepted only while oBUSY=0.
REQ-005 SHALL have port iRW  in  1  0 selects register write, 1 selects register read; sampled with iSTART.
REQ-006 SHALL have port iSLAVE  in  7  target device address; sampled with iSTART.
REQ-007 SHALL have port iREG  in  16  target register address; sampled with iSTART.
REQ-008 SHALL have port iWDAT  in  8  write data; sampled with iSTART.
REQ-009 SHALL have port oRDAT  out  8  read data; holds the last completed read value.
REQ-010 SHALL have port oBUSY  out  1  high from the cycle after an accepted iSTART through the end of STOP.
REQ-011 SHALL have port oDONE  out  1  one-cycle pulse when a transaction ends, whether acked or aborted.
REQ-012 SHALL have port oNACK  out  1  set when a slave NACK is seen; cleared on the next accepted iSTART.
REQ-013 SHALL have port iSCL  in  1  sampled bus SCL level, used for clock stretching.
REQ-014 SHALL have port iSDA  in  1  sampled bus SDA level.
REQ-015 SHALL have port dSCL  out  1  1 drives SCL low, 0 releases it.
REQ-016 SHALL have port dSDA  out  1  1 drives SDA low, 0 releases it.

Function
REQ-017 SHALL use a quarter-tick counter: it reloads QDIV-1, emits a tick at 0, runs only while busy, and restarts on every state change.
REQ-018 SHALL use 4 quarters per bit: Q0 SCL low with SDA updated; Q1 SCL low; Q2 SCL released with SDA sampled; Q3 SCL released.
REQ-019 SHALL stall in Q2 and Q3 while iSCL=0 (clock stretching); counting resumes on the first cycle iSCL=1.
REQ-020 SHALL implement states IDLE, START, SEND, SACK, RSTART, RECV, MNACK, STOP; a frame index selects the byte being sent.
REQ-021 SHALL execute a write as S, {iSLAVE,0}, iREG[15:8], iREG[7:0], iWDAT, P, with a 9th-bit slave ACK after each byte.
REQ-022 SHALL execute a read as S, {iSLAVE,0}, iREG[15:8], iREG[7:0], Sr, {iSLAVE,1}, 8 bits received, master NACK, P.
REQ-023 SHALL send and receive MSB first; received bits shift in at Q2; oRDAT updates once, on entry to MNACK.
REQ-024 SHALL generate START and RSTART as: SDA released with SCL released, SDA low for 2 quarters, then SCL low; RSTART first releases SDA with SCL low.
REQ-025 SHALL generate STOP as: SCL low with SDA low, then SCL released, then SDA released 2 quarters later, then IDLE.
REQ-026 SHALL treat iSDA=1 at Q2 of any SACK as a NACK: set oNACK, skip the remaining bytes, go to STOP.
REQ-027 SHALL pulse oDONE in the cycle after the last STOP quarter, together with oBUSY falling.
REQ-028 SHALL ignore iSTART while oBUSY=1, with no change to the latched request fields.
REQ-029 SHALL honour iSTART in the same cycle oDONE pulses only if oBUSY is already 0 in that cycle; otherwise it is ignored.
REQ-030 SHALL release dSDA during SACK and RECV, and drive it only in the Q0 setup slots.

Reset
REQ-031 SHALL, on RSTN=0, immediately force: dSCL=0, dSDA=0, oBUSY=0, oDONE=0, oNACK=0, oRDAT=8'h00, state IDLE, counters 0.
REQ-032 SHALL, on reset mid-transaction, release the bus without a STOP and report no completion.

Verification
REQ-033 SHALL pass a write with QDIV=4, slave 0x1A, reg 0x3012, data 0x5A, slave acking all -> bytes 0x34,0x30,0x12,0x5A on SDA, oDONE pulse, oNACK=0.
REQ-034 SHALL pass a read of slave 0x1A, reg 0x0100, slave returning 0xC3 -> bytes 0x34,0x01,0x00, Sr, 0x35, master NACK, P, oRDAT=0xC3.
REQ-035 SHALL pass a slave NACK on the address byte -> STOP right after the 9th clock, oNACK=1, oDONE pulse, no register bytes sent.
REQ-036 SHALL pass a clock-stretch test: slave holds SCL low 100 cycles during the ACK of the 2nd byte -> Q2 extended by exactly the hold time, data intact.
REQ-037 SHALL pass a reset mid-byte: RSTN low during the 3rd byte -> dSCL=0 and dSDA=0 the same cycle, no oDONE; the next iSTART completes normally.
REQ-038 SHALL pass a repeated iSTART every cycle while busy -> exactly one transaction, with fields from the first accepted request.
